// File: rtl/aes_block_uart_sequencer.sv
// AES block to UART byte sequencer.
// Takes one NUM_BYTES*8-bit block from the AES output register and feeds it
// to the UART transmitter one byte at a time.
//
// Handshakes:
//   upstream  : a block moves when blk_valid && blk_ready are both high at a
//               rising clk edge; blk_data is sampled only at that edge and the
//               source must hold blk_valid until it is accepted.
//   downstream: tx_drive is a one-cycle start request with tx_byte_in valid in
//               the same cycle; the transmitter answers with a one-cycle
//               tx_done pulse at the end of the stop bit. tx_done outside
//               WAIT_DONE is ignored.
module aes_block_uart_sequencer #(
  parameter int NUM_BYTES    = 16,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 8192,
  localparam int BLK_W = NUM_BYTES * 8,
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  output logic             blk_ready,
  output logic             tx_drive,
  output logic [7:0]       tx_byte_in,
  input  logic             tx_active,
  input  logic             tx_done,
  output logic             busy,
  output logic             blk_done,
  output logic             timeout_err,
  output logic [IDX_W-1:0] byte_idx,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_IDLE = 3'd1;
  localparam logic [2:0] S_DRIVE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam bit               HAS_GAP  = (GAP_CLKS > 0);
  localparam logic [15:0]      GAP_LAST = HAS_GAP ? 16'(GAP_CLKS - 1) : 16'd0;
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  logic [2:0]       state;
  logic [BLK_W-1:0] shift_reg;
  logic [31:0]      tmo_cnt;
  logic [15:0]      gap_cnt;

  logic [31:0]      tmo_next;
  logic             last_byte;
  logic             launch;
  logic [7:0]       head_byte;
  logic [BLK_W-1:0] shift_next;

  assign state_dbg = state;

  // Next-byte selection, saturating timeout increment and the launch condition
  // that moves the FSM into DRIVE from any of its three predecessors.
  always_comb begin
    tmo_next   = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 32'd1;
    last_byte  = (byte_idx == IDX_LAST);
    head_byte  = MSB_FIRST ? shift_reg[BLK_W-1 -: 8] : shift_reg[7:0];
    shift_next = MSB_FIRST ? (shift_reg << 8) : (shift_reg >> 8);
    launch     = 1'b0;
    case (state)
      S_WAIT_IDLE: launch = !tx_active;
      S_WAIT_DONE: launch = tx_done && !last_byte && !HAS_GAP;
      S_GAP:       launch = (gap_cnt == GAP_LAST);
      default:     launch = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      blk_ready   <= 1'b1;
      tx_drive    <= 1'b0;
      tx_byte_in  <= 8'h00;
      busy        <= 1'b0;
      blk_done    <= 1'b0;
      timeout_err <= 1'b0;
      byte_idx    <= '0;
      shift_reg   <= '0;
      tmo_cnt     <= 32'd0;
      gap_cnt     <= 16'd0;
    end else begin
      tx_drive    <= 1'b0;
      blk_done    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (blk_valid && blk_ready) begin
            shift_reg <= blk_data;
            byte_idx  <= '0;
            busy      <= 1'b1;
            blk_ready <= 1'b0;
            state     <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          // Leaves through the launch path once a foreign transfer has ended.
        end
        S_DRIVE: begin
          tmo_cnt <= 32'd0;
          state   <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          tmo_cnt <= tmo_next;
          // tx_done wins over a timeout expiring in the same cycle.
          if (tx_done) begin
            if (last_byte) begin
              blk_done  <= 1'b1;
              busy      <= 1'b0;
              blk_ready <= 1'b1;
              byte_idx  <= '0;
              state     <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              if (HAS_GAP) begin
                gap_cnt <= 16'd0;
                state   <= S_GAP;
              end
            end
          end else if (tmo_next == TMO_LAST) begin
            // Transmitter went silent: drop the rest of the block.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            blk_ready   <= 1'b1;
            byte_idx    <= '0;
            shift_reg   <= '0;
            state       <= S_IDLE;
          end
        end
        S_GAP: begin
          if (!launch) begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (launch) begin
        tx_drive   <= 1'b1;
        tx_byte_in <= head_byte;
        shift_reg  <= shift_next;
        state      <= S_DRIVE;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_uart_sequencer.sv
// Bench for aes_block_uart_sequencer: two instances (MSB-first no gap, and
// LSB-first with a 3-clock gap) share one behavioural UART transmitter.
module tb_aes_block_uart_sequencer;

  localparam int NB  = 16;
  localparam int CPB = 4;
  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         sel = 1'b0;
  logic         tx_mute = 1'b0;
  logic         foreign_busy = 1'b0;
  logic         tx_active;
  logic         tx_done;
  logic         m_active;
  int           m_cnt;

  logic       a_blk_ready, a_tx_drive, a_busy, a_blk_done, a_timeout_err;
  logic [7:0] a_tx_byte_in;
  logic [3:0] a_byte_idx;
  logic [2:0] a_state;
  logic       b_blk_ready, b_tx_drive, b_busy, b_blk_done, b_timeout_err;
  logic [7:0] b_tx_byte_in;
  logic [3:0] b_byte_idx;
  logic [2:0] b_state;

  logic       o_blk_ready, o_tx_drive, o_busy, o_blk_done, o_timeout_err;
  logic [7:0] o_tx_byte_in;
  logic [3:0] o_byte_idx;

  aes_block_uart_sequencer #(.NUM_BYTES(NB), .MSB_FIRST(1'b1), .GAP_CLKS(0), .TIMEOUT_CLKS(TMO)) dut_a (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid & ~sel), .blk_data(blk_data),
    .blk_ready(a_blk_ready), .tx_drive(a_tx_drive), .tx_byte_in(a_tx_byte_in),
    .tx_active(tx_active), .tx_done(tx_done), .busy(a_busy), .blk_done(a_blk_done),
    .timeout_err(a_timeout_err), .byte_idx(a_byte_idx), .state_dbg(a_state)
  );

  aes_block_uart_sequencer #(.NUM_BYTES(NB), .MSB_FIRST(1'b0), .GAP_CLKS(3), .TIMEOUT_CLKS(TMO)) dut_b (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid & sel), .blk_data(blk_data),
    .blk_ready(b_blk_ready), .tx_drive(b_tx_drive), .tx_byte_in(b_tx_byte_in),
    .tx_active(tx_active), .tx_done(tx_done), .busy(b_busy), .blk_done(b_blk_done),
    .timeout_err(b_timeout_err), .byte_idx(b_byte_idx), .state_dbg(b_state)
  );

  always_comb begin
    o_blk_ready   = sel ? b_blk_ready   : a_blk_ready;
    o_tx_drive    = sel ? b_tx_drive    : a_tx_drive;
    o_tx_byte_in  = sel ? b_tx_byte_in  : a_tx_byte_in;
    o_busy        = sel ? b_busy        : a_busy;
    o_blk_done    = sel ? b_blk_done    : a_blk_done;
    o_timeout_err = sel ? b_timeout_err : a_timeout_err;
    o_byte_idx    = sel ? b_byte_idx    : a_byte_idx;
  end

  // Behavioural UART transmitter: a 10-bit frame of CPB clocks per bit,
  // tx_done pulses at the end of the frame unless muted.
  assign tx_active = m_active | foreign_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_active <= 1'b0; tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_active <= 1'b0;
          tx_done  <= !tx_mute;
        end
      end else if (o_tx_drive) begin
        m_cnt <= 10 * CPB; m_active <= 1'b1;
      end
    end
  end

  // ---------------- event logs / scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  int         drv_cyc[$];
  logic [7:0] drv_byte[$];
  int         drv_idx[$];
  int         done_cyc[$];
  int         bdone_cyc[$];
  int         tmo_cyc[$];
  int         acc_cyc[$];
  int         rdy_viol;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_tx_drive) begin
        drv_cyc.push_back(cyc); drv_byte.push_back(o_tx_byte_in); drv_idx.push_back(int'(o_byte_idx));
      end
      if (tx_done) done_cyc.push_back(cyc);
      if (o_blk_done) bdone_cyc.push_back(cyc);
      if (o_timeout_err) tmo_cyc.push_back(cyc);
      if (blk_valid && o_blk_ready) acc_cyc.push_back(cyc);
      if (o_busy && o_blk_ready) rdy_viol++;
    end
  end

  // Reference byte order straight from the byte-order rule.
  function automatic logic [7:0] ref_byte(input logic [127:0] d, input bit msb, input int k);
    logic [127:0] s;
    s = msb ? (d >> (8 * (NB - 1 - k))) : (d >> (8 * k));
    return s[7:0];
  endfunction

  task automatic fill_exp(input logic [127:0] d, input bit msb);
    exp_q.delete();
    for (int k = 0; k < NB; k++) exp_q.push_back(ref_byte(d, msb, k));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    drv_cyc.delete(); drv_byte.delete(); drv_idx.delete(); done_cyc.delete();
    bdone_cyc.delete(); tmo_cyc.delete(); acc_cyc.delete(); rdy_viol = 0;
  endtask

  task automatic send_block(input logic [127:0] d, input bit keep_valid);
    int n0;
    n0 = acc_cyc.size();
    blk_data = d; blk_valid = 1'b1;
    for (int i = 0; i < 300 && acc_cyc.size() == n0; i++) step();
    checks++;
    if (acc_cyc.size() == n0) begin
      errors++; $display("FAIL accept_wait got no acceptance exp acceptance within 300 cycles");
    end
    if (!keep_valid) blk_valid = 1'b0;
  endtask

  task automatic wait_end(input int n_events);
    for (int i = 0; i < 2500 && (bdone_cyc.size() + tmo_cyc.size()) < n_events; i++) step();
    checks++;
    if ((bdone_cyc.size() + tmo_cyc.size()) < n_events) begin
      errors++; $display("FAIL end_wait got %0d end events exp %0d", bdone_cyc.size() + tmo_cyc.size(), n_events);
    end
    step(); step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++; if (o_blk_ready !== 1'b1) begin errors++; $display("FAIL rst_blk_ready got %b exp 1", o_blk_ready); end
    checks++; if (o_tx_drive !== 1'b0) begin errors++; $display("FAIL rst_tx_drive got %b exp 0", o_tx_drive); end
    checks++; if (o_tx_byte_in !== 8'h00) begin errors++; $display("FAIL rst_tx_byte got %h exp 00", o_tx_byte_in); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    checks++; if (o_blk_done !== 1'b0) begin errors++; $display("FAIL rst_blk_done got %b exp 0", o_blk_done); end
    checks++; if (o_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", o_timeout_err); end
    checks++; if (o_byte_idx !== 4'd0) begin errors++; $display("FAIL rst_byte_idx got %0d exp 0", o_byte_idx); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step(); step();
    checks++; if ({o_blk_ready, o_busy, o_tx_drive} !== 3'b100) begin
      errors++; $display("FAIL post_rst_idle got %b exp 100", {o_blk_ready, o_busy, o_tx_drive});
    end
  endtask

  task automatic test_single_msb();
    logic [127:0] d;
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    sel = 1'b0; clear_logs(); fill_exp(d, 1'b1);
    send_block(d, 1'b0); wait_end(1);
    checks++; if (drv_byte.size() != NB) begin errors++; $display("FAIL msb_drive_count got %0d exp %0d", drv_byte.size(), NB); end
    if (drv_byte.size() == NB && done_cyc.size() == NB) begin
      for (int k = 0; k < NB; k++) begin
        checks++; if (drv_byte[k] !== exp_q[k]) begin errors++; $display("FAIL msb_byte%0d got %h exp %h", k, drv_byte[k], exp_q[k]); end
        checks++; if (drv_idx[k] != k) begin errors++; $display("FAIL msb_idx%0d got %0d exp %0d", k, drv_idx[k], k); end
        if (k > 0) begin
          checks++; if (drv_cyc[k] != done_cyc[k-1] + 1) begin
            errors++; $display("FAIL msb_spacing%0d got %0d exp %0d", k, drv_cyc[k], done_cyc[k-1] + 1);
          end
        end
      end
      checks++; if (drv_cyc[0] != acc_cyc[0] + 2) begin errors++; $display("FAIL msb_latency got %0d exp %0d", drv_cyc[0], acc_cyc[0] + 2); end
      checks++; if (bdone_cyc.size() != 1 || bdone_cyc[0] != done_cyc[NB-1] + 1) begin
        errors++; $display("FAIL msb_blk_done got %0d pulses exp 1 pulse at %0d", bdone_cyc.size(), done_cyc[NB-1] + 1);
      end
    end
    checks++; if (rdy_viol != 0) begin errors++; $display("FAIL msb_ready_low got %0d cycles ready while busy exp 0", rdy_viol); end
    checks++; if (tmo_cyc.size() != 0) begin errors++; $display("FAIL msb_no_timeout got %0d exp 0", tmo_cyc.size()); end
  endtask

  task automatic test_gap_lsb();
    logic [127:0] d;
    d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    sel = 1'b1; clear_logs(); fill_exp(d, 1'b0);
    send_block(d, 1'b0); wait_end(1);
    checks++; if (drv_byte.size() != NB) begin errors++; $display("FAIL gap_drive_count got %0d exp %0d", drv_byte.size(), NB); end
    if (drv_byte.size() == NB && done_cyc.size() == NB) begin
      checks++; if (drv_byte[0] !== 8'hFF) begin errors++; $display("FAIL gap_first_byte got %h exp ff", drv_byte[0]); end
      checks++; if (drv_byte[NB-1] !== 8'h00) begin errors++; $display("FAIL gap_last_byte got %h exp 00", drv_byte[NB-1]); end
      for (int k = 0; k < NB; k++) begin
        checks++; if (drv_byte[k] !== exp_q[k]) begin errors++; $display("FAIL gap_byte%0d got %h exp %h", k, drv_byte[k], exp_q[k]); end
        if (k > 0) begin
          checks++; if (drv_cyc[k] != done_cyc[k-1] + 4) begin
            errors++; $display("FAIL gap_spacing%0d got %0d exp %0d", k, drv_cyc[k], done_cyc[k-1] + 4);
          end
        end
      end
      checks++; if (bdone_cyc.size() != 1 || bdone_cyc[0] != done_cyc[NB-1] + 1) begin
        errors++; $display("FAIL gap_blk_done got %0d pulses exp 1 pulse at %0d", bdone_cyc.size(), done_cyc[NB-1] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1, d2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    sel = 1'b0; clear_logs(); fill_exp(d2, 1'b1);
    send_block(d1, 1'b1);
    blk_data = d2;
    for (int i = 0; i < 1500 && acc_cyc.size() < 2; i++) step();
    blk_valid = 1'b0;
    wait_end(2);
    checks++; if (acc_cyc.size() != 2 || drv_byte.size() != 2 * NB || bdone_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_counts got acc=%0d drv=%0d done=%0d exp 2/%0d/2", acc_cyc.size(), drv_byte.size(), bdone_cyc.size(), 2 * NB);
    end else begin
      checks++; if (acc_cyc[1] != bdone_cyc[0]) begin errors++; $display("FAIL b2b_accept got %0d exp %0d", acc_cyc[1], bdone_cyc[0]); end
      checks++; if (drv_cyc[NB] != acc_cyc[1] + 2) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", drv_cyc[NB], acc_cyc[1] + 2); end
      for (int k = 0; k < NB; k++) begin
        checks++; if (drv_byte[NB+k] !== exp_q[k]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", k, drv_byte[NB+k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    sel = 1'b0; clear_logs(); tx_mute = 1'b1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_end(1);
    checks++; if (tmo_cyc.size() != 1 || drv_cyc.size() != 1) begin
      errors++; $display("FAIL tmo_counts got tmo=%0d drv=%0d exp 1/1", tmo_cyc.size(), drv_cyc.size());
    end else begin
      checks++; if (tmo_cyc[0] != drv_cyc[0] + TMO) begin errors++; $display("FAIL tmo_delay got %0d exp %0d", tmo_cyc[0] - drv_cyc[0], TMO); end
    end
    checks++; if (bdone_cyc.size() != 0) begin errors++; $display("FAIL tmo_no_blk_done got %0d exp 0", bdone_cyc.size()); end
    checks++; if ({o_blk_ready, o_busy} !== 2'b10) begin errors++; $display("FAIL tmo_idle got %b exp 10", {o_blk_ready, o_busy}); end
    tx_mute = 1'b0;
    repeat (50) step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    bit           found;
    sel = 1'b0; clear_logs(); found = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (o_tx_drive && o_byte_idx == 4'd7) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_find_byte7 got none exp drive of byte 7"); end
    reset_n = 1'b0;
    #1;
    checks++; if (o_tx_drive !== 1'b0) begin errors++; $display("FAIL mid_async_drive got %b exp 0", o_tx_drive); end
    checks++; if ({o_blk_ready, o_busy, o_blk_done, o_timeout_err, o_tx_byte_in, o_byte_idx} !== {4'b1000, 8'h00, 4'h0}) begin
      errors++; $display("FAIL mid_async_outputs got %h exp %h", {o_blk_ready, o_busy, o_blk_done, o_timeout_err, o_tx_byte_in, o_byte_idx}, {4'b1000, 8'h00, 4'h0});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) step();
    checks++; if (bdone_cyc.size() + tmo_cyc.size() != 0) begin
      errors++; $display("FAIL mid_no_pulse got %0d pulses exp 0", bdone_cyc.size() + tmo_cyc.size());
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    clear_logs(); fill_exp(d, 1'b1);
    send_block(d, 1'b0); wait_end(1);
    checks++; if (drv_byte.size() != NB) begin
      errors++; $display("FAIL mid_restart_count got %0d exp %0d", drv_byte.size(), NB);
    end else begin
      checks++; if (drv_idx[0] != 0 || drv_byte[0] !== exp_q[0]) begin
        errors++; $display("FAIL mid_restart_first got idx %0d byte %h exp idx 0 byte %h", drv_idx[0], drv_byte[0], exp_q[0]);
      end
      for (int k = 1; k < NB; k++) begin
        checks++; if (drv_byte[k] !== exp_q[k]) begin errors++; $display("FAIL mid_byte%0d got %h exp %h", k, drv_byte[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_tx_active_hold();
    int f;
    sel = 1'b0; clear_logs(); foreign_busy = 1'b1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (19) step();
    checks++; if (drv_cyc.size() != 0) begin errors++; $display("FAIL hold_no_drive got %0d drives exp 0", drv_cyc.size()); end
    foreign_busy = 1'b0;
    f = cyc;
    wait_end(1);
    checks++; if (drv_cyc.size() != NB) begin
      errors++; $display("FAIL hold_drive_count got %0d exp %0d", drv_cyc.size(), NB);
    end else begin
      checks++; if (drv_cyc[0] != f + 1) begin errors++; $display("FAIL hold_first_drive got %0d exp %0d", drv_cyc[0], f + 1); end
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    bit           s;
    int           gap;
    for (int it = 0; it < 6; it++) begin
      s = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      gap = s ? 3 : 0;
      sel = s; clear_logs(); fill_exp(d, !s);
      repeat ($urandom_range(0, 5)) step();
      send_block(d, 1'b0); wait_end(1);
      checks++; if (drv_byte.size() != NB || done_cyc.size() != NB) begin
        errors++; $display("FAIL rnd%0d_count got %0d drives exp %0d", it, drv_byte.size(), NB);
      end else begin
        for (int k = 0; k < NB; k++) begin
          checks++; if (drv_byte[k] !== exp_q[k]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", it, k, drv_byte[k], exp_q[k]); end
          if (k > 0) begin
            checks++; if (drv_cyc[k] != done_cyc[k-1] + 1 + gap) begin
              errors++; $display("FAIL rnd%0d_spacing%0d got %0d exp %0d", it, k, drv_cyc[k], done_cyc[k-1] + 1 + gap);
            end
          end
        end
        checks++; if (bdone_cyc.size() != 1 || bdone_cyc[0] != done_cyc[NB-1] + 1) begin
          errors++; $display("FAIL rnd%0d_blk_done got %0d pulses exp 1 at %0d", it, bdone_cyc.size(), done_cyc[NB-1] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_gap_lsb();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_tx_active_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
